// File: rtl/output_port_hs.sv
// Buffered output port: captures bus bytes into a small FIFO, hands them out over a
// valid/ack handshake, and drives a read-to-clear status byte back onto the shared bus.
module output_port_hs #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  inout  wire  [WIDTH-1:0] wBus,
  input  logic             iLoad,
  input  logic             iStatusEn,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  input  logic             iAck,
  output logic             oFull
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countNext;
  logic             ovf;
  logic             valid;
  logic             full;
  logic             push;
  logic             pop;
  logic             overflow;
  logic [WIDTH-1:0] status;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a load paired with an ack.
  always_comb begin
    pop       = valid & iAck;
    push      = iLoad & (~full | pop);
    overflow  = iLoad & full & ~pop;
    countNext = count;
    if (push && !pop) begin
      countNext = CW'(count + CW'(1));
    end else if (pop && !push) begin
      countNext = CW'(count - CW'(1));
    end
  end

  // Status word: {0.., ovf, valid, full}; reflects state as of the last edge.
  assign status = WIDTH'({ovf, valid, full});
  assign wBus   = iStatusEn ? status : {WIDTH{1'bz}};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      full  <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wBus;
        wrPtr      <= AW'(wrPtr + AW'(1));
      end
      if (pop) begin
        rdPtr <= AW'(rdPtr + AW'(1));
      end
      count <= countNext;
      valid <= (countNext != '0);
      full  <= (countNext == CW'(DEPTH));
      // A fresh overflow beats the read-to-clear on the same edge.
      if (overflow) begin
        ovf <= 1'b1;
      end else if (iStatusEn) begin
        ovf <= 1'b0;
      end
    end
  end

  assign oData  = mem[rdPtr];
  assign oValid = valid;
  assign oFull  = full;

  // The controller must never load while the status byte owns the bus.
  noBusContention: assert property (@(posedge iClk) disable iff (!iRst_n) !(iLoad && iStatusEn));
  countInRange:    assert property (@(posedge iClk) disable iff (!iRst_n) count <= CW'(DEPTH));

endmodule

// File: tb/tb_output_port_hs.sv
// Directed bench for output_port_hs: per-cycle vector table plus reset, wrap and mid-operation reset sequences.
module tb_output_port_hs;

  logic       iClk;
  logic       iRst_n;
  wire  [7:0] wBus;
  logic       iLoad;
  logic       iStatusEn;
  logic [7:0] oData;
  logic       oValid;
  logic       iAck;
  logic       oFull;

  logic       drv;
  logic [7:0] dval;

  int checks;
  int errors;

  assign wBus = drv ? dval : 8'hzz;

  output_port_hs #(.WIDTH(8), .DEPTH(2)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .wBus      (wBus),
    .iLoad     (iLoad),
    .iStatusEn (iStatusEn),
    .oData     (oData),
    .oValid    (oValid),
    .iAck      (iAck),
    .oFull     (oFull)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       st;
    logic       ack;
    logic       expValid;
    logic       expFull;
    logic       chkData;
    logic [7:0] expData;
    logic [7:0] expStatus;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [7:0] din, input logic st, input logic ack,
                              input logic ev, input logic ef, input logic cd, input logic [7:0] ed,
                              input logic [7:0] es);
    vec_t v;
    v.ld = ld; v.din = din; v.st = st; v.ack = ack;
    v.expValid = ev; v.expFull = ef; v.chkData = cd; v.expData = ed; v.expStatus = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] din, input logic st, input logic ack);
    iLoad     = ld;
    drv       = ld;
    dval      = din;
    iStatusEn = st;
    iAck      = ack;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    iRst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset asserted mid-cycle: outputs clear immediately, status reads zero.
    @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    chk("rst valid", 32'(oValid), 32'd0);
    chk("rst full", 32'(oFull), 32'd0);
    chk("rst data", 32'(oData), 32'h00);
    iStatusEn = 1'b1;
    #1;
    chk("rst status", 32'(wBus), 32'h00);
    iStatusEn = 1'b0;
    @(negedge iClk);
    #1 iRst_n = 1'b1;
    @(posedge iClk);
    #1;

    //           ld    din    st    ack   valid full  chkD  data   status
    // single transfer
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h02));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
    // fill and overflow, read-to-clear, drain in order
    vecs.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00));
    vecs.push_back(mk(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h07));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h03));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    // full with simultaneous load and ack
    vecs.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 8'h00));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 8'h03));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA2, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    // count=1 with simultaneous load and ack; ack while empty is ignored
    vecs.push_back(mk(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB1, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].din, vecs[i].st, vecs[i].ack);
      @(negedge iClk);
      chk($sformatf("v%0d valid", i), 32'(oValid), 32'(vecs[i].expValid));
      chk($sformatf("v%0d full", i), 32'(oFull), 32'(vecs[i].expFull));
      if (vecs[i].chkData) chk($sformatf("v%0d data", i), 32'(oData), 32'(vecs[i].expData));
      if (vecs[i].st) chk($sformatf("v%0d status", i), 32'(wBus), 32'(vecs[i].expStatus));
      @(posedge iClk);
      #1;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Pointer wrap-around: loads and acks interleaved one cycle apart.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      @(negedge iClk);
      chk($sformatf("wrap%0d pre-valid", i), 32'(oValid), 32'd0);
      @(posedge iClk);
      #1;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge iClk);
      chk($sformatf("wrap%0d valid", i), 32'(oValid), 32'd1);
      chk($sformatf("wrap%0d data", i), 32'(oData), 32'(i));
      @(posedge iClk);
      #1;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge iClk);
    chk("wrap drained", 32'(oValid), 32'd0);
    @(posedge iClk);
    #1;

    // Reset mid-operation with two bytes buffered.
    drive(1'b1, 8'h71, 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    drive(1'b1, 8'h72, 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre-rst full", 32'(oFull), 32'd1);
    chk("pre-rst data", 32'(oData), 32'h71);
    #1 iRst_n = 1'b0;
    #1;
    chk("mid-rst valid", 32'(oValid), 32'd0);
    chk("mid-rst full", 32'(oFull), 32'd0);
    chk("mid-rst data", 32'(oData), 32'h00);
    #1 iRst_n = 1'b1;
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    @(posedge iClk);
    #1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("post-rst valid", 32'(oValid), 32'd1);
    chk("post-rst full", 32'(oFull), 32'd0);
    chk("post-rst data", 32'(oData), 32'hC3);
    chk("post-rst status", 32'(wBus), 32'h02);
    @(posedge iClk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_hs.md
# output_port_hs

Buffered handshake output port for the SAP-2 datapath. The block captures a byte from the shared bus `wBus` when the controller asserts the load strobe. It holds the byte in a small FIFO and presents it to an external device through a valid/acknowledge handshake. On request it drives a status byte back onto `wBus` through tri-state drivers, so a program can poll port readiness and overflow.

## Interface
- `WIDTH`, 8: data width in bits; also the bus width.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `iClk`  in  1  system clock; all state updates on the rising edge.
- `iRst_n`  in  1  asynchronous active-low reset.
- `wBus`  inout  WIDTH  shared bus. Sampled when `iLoad`=1. Driven with the status byte when `iStatusEn`=1. High-Z otherwise.
- `iLoad`  in  1  capture `wBus` into the FIFO on this edge.
- `iStatusEn`  in  1  drive the status byte onto `wBus` (combinational enable).
- `oData`  out  WIDTH  head-of-FIFO byte to the external device.
- `oValid`  out  1  `oData` holds an unacknowledged byte.
- `iAck`  in  1  external device accepts `oData`; sampled at the rising edge.
- `oFull`  out  1  FIFO holds DEPTH entries.

## Operation
- Storage:
  - DEPTH×WIDTH register array.
  - Read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter `count` of log2(DEPTH)+1 bits, range 0..DEPTH.
- Push:
  - Occurs when `iLoad`=1 and (count<DEPTH, or a pop occurs on the same edge).
  - Writes `wBus` at the write pointer; write pointer +1.
- Pop:
  - Occurs when `oValid`=1 and `iAck`=1.
  - Read pointer +1.
  - `iAck` while `oValid`=0 is ignored and changes no state.
- Simultaneous push and pop:
  - `count` unchanged.
  - When full, the push is accepted because the pop frees the slot on the same edge.
  - When count=1, the new byte becomes head on the next cycle.
- Overflow:
  - `iLoad` while count=DEPTH with no simultaneous pop drops the byte.
  - Sets sticky flag `ovf`; storage and pointers are unchanged.
- `ovf` clear:
  - Clears on the edge following any cycle in which `iStatusEn`=1 (read-to-clear).
  - If a new overflow occurs on that same edge, set wins.
- Outputs:
  - `oValid` = (count≠0).
  - `oData` = entry at the read pointer, stable while `oValid`=1 and no pop occurs.
  - `oFull` = (count=DEPTH).
- Status byte driven onto `wBus` when `iStatusEn`=1:
  - bit0 = `oFull`
  - bit1 = `oValid`
  - bit2 = `ovf`
  - bits WIDTH-1..3 = 0
- Bus contention: the controller never asserts `iLoad` and `iStatusEn` together. If both are asserted, the push uses the status byte as the bus value. This case is excluded from verification except as an assertion failure.
- Reset (`iRst_n`=0, asynchronous):
  - Pointers, `count` and `ovf` = 0.
  - `oValid`=0, `oFull`=0.
  - `oData`=0 (array cleared).
  - `wBus` high-Z unless `iStatusEn`.
- Reset mid-handshake discards all buffered bytes. No acknowledge is owed after reset.

## Timing
- Push latency: byte loaded at edge k is visible with `oValid`=1 right after edge k when the FIFO was empty. Otherwise it appears after all earlier bytes are popped.
- Pop: head advances right after the acknowledging edge. The next byte, if any, is valid in the same cycle, so back-to-back acks drain one byte per cycle.
- Status drive is combinational:
  - `wBus` is valid within the cycle `iStatusEn` is high.
  - It reflects state as of the last edge.
  - It returns to high-Z in the cycle `iStatusEn` falls.
- `oFull` and `oValid` are registered-state decodes with no combinational path from `iAck` or `iLoad`.

## Test plan
- Reset then idle: assert `iRst_n`=0 mid-cycle → `oValid`=0, `oFull`=0, `oData`=0x00, `wBus`=Z. Status read gives 0x00.
- Single transfer:
  - Stimulus: load 0x5A; hold `iAck`=0 three cycles, then `iAck`=1 one cycle.
  - Response: `oValid`=1 with `oData`=0x5A for four cycles, then `oValid`=0. Status after the load = 0x02.
- Fill and overflow:
  - Stimulus: load 0x11, 0x22, 0x33 with no ack.
  - Response: `oFull`=1 after the second load; 0x33 dropped; status=0x07.
  - Second status read = 0x03 (`ovf` cleared).
  - Acks then return 0x11, 0x22 in order.
- Full with simultaneous load and ack:
  - Stimulus: FIFO holds 0xA1, 0xA2; same edge loads 0xA3 with `iAck`=1.
  - Response: `ovf` stays 0; `oData` sequence 0xA2, 0xA3; `oFull` stays 1 until the next pop.
- Pointer wrap-around: stream 0x00..0x09 with loads and acks interleaved one cycle apart → `oData` sequence exactly 0x00..0x09, no loss or duplication.
- Reset mid-operation:
  - Stimulus: with two bytes buffered, pulse `iRst_n` low between edges.
  - Response: outputs zero immediately; a subsequent load of 0xC3 is the next valid byte.
